// File: rtl/be8_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, step count
// and the packed control word driven towards the bus mux and datapath.
package be8_pkg;

  localparam int NSTEPS_DEF = 5;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_INP = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Eight active-low bus enables followed by eleven active-high strobes.
  typedef struct packed {
    logic don, aon, bon, ion, con, eon, ron, non;
    logic mi, ri, ii, ai, bi, oi, ce, j, fi, su, hlt;
  } ctrl_t;

  localparam ctrl_t CTRL_EMPTY = ctrl_t'({8'hFF, 11'h000});

  function automatic logic ctrl_is_empty(input ctrl_t c);
    return c == CTRL_EMPTY;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: (opcode, micro-step, flags) -> control word.
// Fetch occupies steps 0-1 for every opcode; execute words live in steps 2-4.
module microcode_rom
  import be8_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic [3:0]        i_opcode,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_cf,
  input  logic              i_zf,
  output ctrl_t             o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_EMPTY;
    case (i_step)
      STEP_W'(0): begin
        o_ctrl.con = 1'b0;
        o_ctrl.mi  = 1'b1;
      end
      STEP_W'(1): begin
        o_ctrl.ron = 1'b0;
        o_ctrl.ii  = 1'b1;
        o_ctrl.ce  = 1'b1;
      end
      STEP_W'(2): begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_ctrl.ion = 1'b0;
            o_ctrl.mi  = 1'b1;
          end
          OP_LDI: begin
            o_ctrl.ion = 1'b0;
            o_ctrl.ai  = 1'b1;
          end
          OP_JMP: begin
            o_ctrl.ion = 1'b0;
            o_ctrl.j   = 1'b1;
          end
          OP_JC: if (i_cf) begin
            o_ctrl.ion = 1'b0;
            o_ctrl.j   = 1'b1;
          end
          OP_JZ: if (i_zf) begin
            o_ctrl.ion = 1'b0;
            o_ctrl.j   = 1'b1;
          end
          OP_INP: begin
            o_ctrl.non = 1'b0;
            o_ctrl.ai  = 1'b1;
          end
          OP_OUT: begin
            o_ctrl.aon = 1'b0;
            o_ctrl.oi  = 1'b1;
          end
          OP_HLT: o_ctrl.hlt = 1'b1;
          default: ;
        endcase
      end
      STEP_W'(3): begin
        case (i_opcode)
          OP_LDA: begin
            o_ctrl.ron = 1'b0;
            o_ctrl.ai  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_ctrl.ron = 1'b0;
            o_ctrl.bi  = 1'b1;
          end
          OP_STA: begin
            o_ctrl.aon = 1'b0;
            o_ctrl.ri  = 1'b1;
          end
          default: ;
        endcase
      end
      STEP_W'(4): begin
        if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
          o_ctrl.eon = 1'b0;
          o_ctrl.ai  = 1'b1;
          o_ctrl.fi  = 1'b1;
          o_ctrl.su  = (i_opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// CPU control unit: micro-step counter, halt latch and debug/reset override.
// Optional SEQ_EARLY_RESET_EN: skip idle execute steps by looking ahead one step.
module microcode_sequencer
  import be8_pkg::*;
#(
  parameter int NSTEPS = NSTEPS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ENA,
  input  logic                      DBG,
  input  logic [3:0]                OPCODE,
  input  logic                      CF,
  input  logic                      ZF,
  output logic                      DOn,
  output logic                      AOn,
  output logic                      BOn,
  output logic                      IOn,
  output logic                      COn,
  output logic                      EOn,
  output logic                      ROn,
  output logic                      NOn,
  output logic                      MI,
  output logic                      RI,
  output logic                      II,
  output logic                      AI,
  output logic                      BI,
  output logic                      OI,
  output logic                      CE,
  output logic                      J,
  output logic                      FI,
  output logic                      SU,
  output logic                      HALTED,
  output logic [$clog2(NSTEPS)-1:0] STEP
);

  localparam int STEP_W = $clog2(NSTEPS);

  logic [STEP_W-1:0] r_step;
  logic              r_halted;
  ctrl_t             w_rom;
  ctrl_t             w_ctrl;
  logic              w_last;
  logic              w_early;
  logic [STEP_W-1:0] w_step_next;

  microcode_rom #(.STEP_W(STEP_W)) u_rom (
    .i_opcode (OPCODE),
    .i_step   (r_step),
    .i_cf     (CF),
    .i_zf     (ZF),
    .o_ctrl   (w_rom)
  );

  assign w_last = (r_step == STEP_W'(NSTEPS - 1));

`ifdef SEQ_EARLY_RESET_EN
  logic [STEP_W-1:0] w_step_inc;
  ctrl_t             w_rom_nxt;

  assign w_step_inc = r_step + STEP_W'(1);

  microcode_rom #(.STEP_W(STEP_W)) u_rom_nxt (
    .i_opcode (OPCODE),
    .i_step   (w_step_inc),
    .i_cf     (CF),
    .i_zf     (ZF),
    .o_ctrl   (w_rom_nxt)
  );

  // Fetch always runs to T2; only execute steps may end the instruction early.
  assign w_early = (r_step >= STEP_W'(2)) && !w_last && ctrl_is_empty(w_rom_nxt);
`else
  assign w_early = 1'b0;
`endif

  assign w_step_next = (w_last || w_early) ? '0 : r_step + STEP_W'(1);

  // Override priority: reset, then debug, then halt, then the decoded word.
  always_comb begin
    w_ctrl = CTRL_EMPTY;
    if (!rst_n) begin
      w_ctrl = CTRL_EMPTY;
    end else if (DBG) begin
      w_ctrl.don = 1'b0;
    end else if (!r_halted) begin
      w_ctrl = w_rom;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (ENA && !DBG && !r_halted) begin
      r_step <= w_step_next;
      if (w_ctrl.hlt) r_halted <= 1'b1;
    end
  end

  assign {DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn} =
    {w_ctrl.don, w_ctrl.aon, w_ctrl.bon, w_ctrl.ion,
     w_ctrl.con, w_ctrl.eon, w_ctrl.ron, w_ctrl.non};
  assign {MI, RI, II, AI, BI, OI, CE, J, FI, SU} =
    {w_ctrl.mi, w_ctrl.ri, w_ctrl.ii, w_ctrl.ai, w_ctrl.bi,
     w_ctrl.oi, w_ctrl.ce, w_ctrl.j, w_ctrl.fi, w_ctrl.su};
  assign HALTED = r_halted;
  assign STEP   = r_step;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomized self-checking bench for microcode_sequencer against a table-driven
// reference model of the instruction set (honours SEQ_EARLY_RESET_EN).
module tb_microcode_sequencer;

  localparam int NS = 5;
  localparam logic [17:0] W_EMPTY = {8'hFF, 10'h000};
  localparam logic [17:0] W_DBG   = {8'h7F, 10'h000};
  // strobe masks in port order MI RI II AI BI OI CE J FI SU
  localparam logic [9:0] S_MI = 10'h200, S_RI = 10'h100, S_II = 10'h080, S_AI = 10'h040,
                         S_BI = 10'h020, S_OI = 10'h010, S_CE = 10'h008, S_J  = 10'h004,
                         S_FI = 10'h002, S_SU = 10'h001;
  // bus sources: 0 none, 1 D, 2 A, 3 B, 4 I, 5 C, 6 E, 7 R, 8 N
  localparam int SRC_A = 2, SRC_I = 4, SRC_C = 5, SRC_E = 6, SRC_R = 7, SRC_N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ENA = 1'b0, DBG = 1'b0, CF = 1'b0, ZF = 1'b0;
  logic [3:0] OPCODE = 4'h0;
  logic DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn;
  logic MI, RI, II, AI, BI, OI, CE, J, FI, SU, HALTED;
  logic [2:0] STEP;

  int errors = 0;
  int checks = 0;
  int m_step = 0;
  bit m_halted = 1'b0;

  always #5 clk = ~clk;

  microcode_sequencer #(.NSTEPS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .ENA(ENA), .DBG(DBG), .OPCODE(OPCODE), .CF(CF), .ZF(ZF),
    .DOn(DOn), .AOn(AOn), .BOn(BOn), .IOn(IOn), .COn(COn), .EOn(EOn), .ROn(ROn), .NOn(NOn),
    .MI(MI), .RI(RI), .II(II), .AI(AI), .BI(BI), .OI(OI), .CE(CE), .J(J), .FI(FI), .SU(SU),
    .HALTED(HALTED), .STEP(STEP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h step=%0d op=%0h t=%0t", tag, got, exp, m_step, OPCODE, $time);
    end
  endtask

  function automatic logic [17:0] mk(input int src, input logic [9:0] strb);
    logic [7:0] en;
    en = (src == 0) ? 8'hFF : ~(8'h80 >> (src - 1));
    return {en, strb};
  endfunction

  // Reference: instruction table written directly from the opcode list.
  function automatic logic [17:0] ref_word(input int op, input int st, input bit cf,
                                           input bit zf, output bit hlt);
    int e;
    hlt = 1'b0;
    if (st == 0) return mk(SRC_C, S_MI);
    if (st == 1) return mk(SRC_R, S_II | S_CE);
    e = st - 2;
    case (op)
      1: if (e == 0) return mk(SRC_I, S_MI); else if (e == 1) return mk(SRC_R, S_AI);
      2: if (e == 0) return mk(SRC_I, S_MI); else if (e == 1) return mk(SRC_R, S_BI);
         else if (e == 2) return mk(SRC_E, S_AI | S_FI);
      3: if (e == 0) return mk(SRC_I, S_MI); else if (e == 1) return mk(SRC_R, S_BI);
         else if (e == 2) return mk(SRC_E, S_AI | S_FI | S_SU);
      4: if (e == 0) return mk(SRC_I, S_MI); else if (e == 1) return mk(SRC_A, S_RI);
      5: if (e == 0) return mk(SRC_I, S_AI);
      6: if (e == 0) return mk(SRC_I, S_J);
      7: if (e == 0 && cf) return mk(SRC_I, S_J);
      8: if (e == 0 && zf) return mk(SRC_I, S_J);
      9: if (e == 0) return mk(SRC_N, S_AI);
      14: if (e == 0) return mk(SRC_A, S_OI);
      15: if (e == 0) hlt = 1'b1;
      default: ;
    endcase
    return W_EMPTY;
  endfunction

  function automatic logic [17:0] exp_word();
    bit h;
    if (!rst_n) return W_EMPTY;
    if (DBG) return W_DBG;
    if (m_halted) return W_EMPTY;
    return ref_word(int'(OPCODE), m_step, CF, ZF, h);
  endfunction

  function automatic logic [17:0] obs();
    return {DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn, MI, RI, II, AI, BI, OI, CE, J, FI, SU};
  endfunction

  // Called just after a rising edge with the inputs that were present at it.
  task automatic model_edge();
    bit h, h2;
    logic [17:0] w;
    int nxt;
    if (!rst_n) begin
      m_step = 0;
      m_halted = 1'b0;
    end else if (ENA && !DBG && !m_halted) begin
      w = ref_word(int'(OPCODE), m_step, CF, ZF, h);
      if (h) m_halted = 1'b1;
      nxt = m_step + 1;
      if (nxt == NS) nxt = 0;
`ifdef SEQ_EARLY_RESET_EN
      if (m_step >= 2 && nxt != 0 && ref_word(int'(OPCODE), nxt, CF, ZF, h2) == W_EMPTY && !h2)
        nxt = 0;
`endif
      m_step = nxt;
    end
  endtask

  task automatic drive(input bit ena, input bit dbg, input logic [3:0] op, input bit cf,
                       input bit zf);
    logic [17:0] o;
    int lows;
    ENA = ena; DBG = dbg; OPCODE = op; CF = cf; ZF = zf;
    @(negedge clk);
    o = obs();
    lows = 0;
    for (int i = 10; i < 18; i++) if (!o[i]) lows++;
    check("word", 32'(o), 32'(exp_word()));
    check("step", 32'(STEP), 32'(m_step));
    check("halted", 32'(HALTED), 32'(m_halted));
    check("onehot", 32'(lows <= 1), 32'd1);
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    m_step = 0;
    m_halted = 1'b0;
    #2;
    check("rst_halted", 32'(HALTED), 32'd0);
    check("rst_step", 32'(STEP), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic finish_instr(input logic [3:0] op);
    for (int k = 0; k < 8 && m_step != 0; k++) begin
      drive(1'b1, 1'b0, op, 1'b0, 1'b0);
      adv();
    end
    check("instr_end", 32'(STEP), 32'd0);
  endtask

  initial begin
    logic [3:0] cur_op;
    int frozen;

    // Reset held across two clocks
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    adv();
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    adv();
    rst_n = 1'b1;

    // ADD: fetch words then T4 ALU write-back
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    check("t0_COn", 32'(COn), 32'd0);
    check("t0_MI", 32'(MI), 32'd1);
    adv();
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    check("t1_ROn", 32'(ROn), 32'd0);
    check("t1_II_CE", 32'({II, CE}), 32'd3);
    check("t1_others", 32'({DOn, AOn, BOn, IOn, COn, EOn, NOn}), 32'h7F);
    adv();
    for (int s = 2; s < 4; s++) begin
      drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
      adv();
    end
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    check("add_t4", 32'({EOn, AI, FI, SU}), 32'b0110);
    adv();
    // SUB: same T4 plus SU
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
      adv();
    end
    drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    check("sub_t4", 32'({EOn, AI, FI, SU}), 32'b0111);
    adv();

    // JC not taken
    for (int s = 0; s < 2; s++) begin
      drive(1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
      adv();
    end
    drive(1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
    check("jc_empty", 32'(obs()), 32'(W_EMPTY));
    adv();
`ifdef SEQ_EARLY_RESET_EN
    check("jc_next_step", 32'(STEP), 32'd0);
`else
    check("jc_next_step", 32'(STEP), 32'd3);
`endif
    finish_instr(4'h7);

    // HLT: latch, freeze, then reset clears
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      adv();
    end
    check("hlt_set", 32'(HALTED), 32'd1);
    frozen = m_step;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      check("hlt_frozen", 32'(STEP), 32'(frozen));
      check("hlt_enables", 32'(obs() >> 10), 32'hFF);
      adv();
    end
    pulse_reset();

    // DBG at T3 of LDA
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
      adv();
    end
    drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
    check("dbg_word", 32'({DOn, ROn, AI}), 32'b010);
    adv();
    check("dbg_step_held", 32'(STEP), 32'd3);
    drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    check("dbg_resume", 32'({ROn, AI}), 32'b01);
    adv();
    finish_instr(4'h1);

    // Sweep every opcode over a full instruction
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < NS; k++) begin
        drive(1'b1, 1'b0, 4'(op), 1'($urandom_range(1)), 1'($urandom_range(1)));
        if (m_step == 2 && op >= 10 && op <= 13)
          check("undef_empty", 32'(obs()), 32'(W_EMPTY));
        adv();
        if (m_step == 0) break;
      end
      if (m_halted) pulse_reset();
    end

    // Randomized traffic
    cur_op = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if (m_step == 0) cur_op = 4'($urandom_range(15));
      if ($urandom_range(199) == 0 || (m_halted && $urandom_range(19) == 0)) begin
        rst_n = 1'b0;
        m_step = 0;
        m_halted = 1'b0;
        drive(1'b1, 1'b0, cur_op, 1'b0, 1'b0);
        adv();
        rst_n = 1'b1;
      end else begin
        drive(1'($urandom_range(7) != 0), 1'($urandom_range(15) == 0), cur_op,
              1'($urandom_range(1)), 1'($urandom_range(1)));
        adv();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Control unit for the 8-bit CPU.
- Holds the micro-step counter and decodes the instruction-register opcode, current step and ALU flags into one control word per cycle.
- The control word contains the eight active-low bus output enables that select the bus-mux source, plus the active-high load/count strobes for every datapath register.
- Sits directly upstream of the bus mux and drives all of its select inputs.

## Interface
Parameters:
- NSTEPS, 5, micro-steps per instruction (T0..T4); step counter width is $clog2(NSTEPS).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ENA  in  1  clock enable; state holds when 0
- DBG  in  1  debug bus override
- OPCODE  in  4  IR[7:4]
- CF  in  1  registered carry flag
- ZF  in  1  registered zero flag
- DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn  out  1 each  active-low bus-mux output enables
- MI, RI, II, AI, BI, OI  out  1 each  load strobes: MAR, RAM, IR, A, B, output
- CE  out  1  PC increment
- J  out  1  PC load from bus
- FI  out  1  flags load
- SU  out  1  ALU subtract
- HALTED  out  1  halt latch
- STEP  out  $clog2(NSTEPS)  current micro-step

## Operation
- At most one output enable is low in any cycle. Every enable is high when the word is empty.
- Fetch, all opcodes:
  - T0: COn, MI
  - T1: ROn, II, CE
- Execute steps (T2, T3, T4):
  - 0000 NOP: none
  - 0001 LDA: IOn MI | ROn AI
  - 0010 ADD: IOn MI | ROn BI | EOn AI FI
  - 0011 SUB: IOn MI | ROn BI | EOn AI FI SU
  - 0100 STA: IOn MI | AOn RI
  - 0101 LDI: IOn AI
  - 0110 JMP: IOn J
  - 0111 JC: IOn J if CF=1, else empty
  - 1000 JZ: IOn J if ZF=1, else empty
  - 1001 INP: NOn AI
  - 1110 OUT: AOn OI
  - 1111 HLT: HLT at T2
  - 1010 to 1101: treated as NOP
- Step counter, when ENA=1: increments, and wraps from NSTEPS-1 to 0.
- HLT decoded at T2 with ENA=1 sets HALTED on that edge.
  - HALTED=1: step frozen and the control word is empty.
  - Only reset clears HALTED.
- DBG=1 overrides everything else:
  - DOn low, all other enables high, all strobes 0.
  - Step counter frozen.
  - DBG has priority over HALTED. DBG does not clear HALTED.
- CF and ZF are sampled combinationally in the same cycle as T2.

## Timing
- Control outputs are combinational from STEP, OPCODE, CF, ZF, HALTED, DBG and rst_n. Datapath registers consume them on the next rising clk.
- Latency: a control word is valid for exactly one enabled cycle per step.
- Instruction length: LDA/STA 4 cycles, ADD/SUB 5 cycles, others 3 cycles with early reset (see Configuration), otherwise 5.
- While rst_n=0:
  - STEP=0 and HALTED=0.
  - All enables forced high and all strobes forced 0.
- First enabled cycle after reset release issues the T0 fetch word.
- Reset mid-instruction aborts immediately; no partial write occurs after rst_n falls.
- ENA=0: STEP and HALTED hold. Outputs keep decoding the held step. The datapath obeys the same ENA, so no double loads occur.

## Configuration
- SEQ_EARLY_RESET_EN defined: an empty next micro-step resets STEP to 0 instead of executing idle cycles.
  - Decision is made by decoding step+1 for the current opcode and flags.
  - A not-taken JC/JZ and NOP complete in 3 cycles.
- SEQ_EARLY_RESET_EN undefined: every instruction takes exactly NSTEPS cycles.

## Structure
- Shared package be8_pkg holds:
  - opcode localparams (OP_NOP ... OP_HLT)
  - NSTEPS default
  - packed control-word typedef ctrl_t with fields for the eight enables and the eleven strobes
  - constant CTRL_EMPTY
- Sub-module microcode_rom: purely combinational (opcode, step, CF, ZF) -> ctrl_t. It is reused for the step+1 lookahead when SEQ_EARLY_RESET_EN is defined.
- Top level keeps the step counter, halt latch, DBG/reset override muxing and the unpacking into ports.

## Test plan
- Reset then 2 enabled clocks:
  - Cycle 1: COn=0, MI=1.
  - Cycle 2: ROn=0, II=1, CE=1, all other enables high.
- OPCODE=0010 through T0..T4:
  - T4 shows EOn=0, AI=1, FI=1, SU=0.
  - With 0011 the same step also shows SU=1.
- OPCODE=0111, CF=0 at T2:
  - Empty word.
  - STEP returns to 0 after T2 with the macro defined, after T4 without it.
- OPCODE=1111:
  - HALTED=1 after the T2 edge.
  - STEP frozen at its next value and enables all high for 10 clocks.
  - rst_n pulse clears HALTED.
- DBG=1 at T3 of LDA:
  - DOn=0, ROn=1, AI=0, STEP held.
  - After DBG=0, T3 resumes with ROn=0, AI=1.
- Sweep all opcodes and steps:
  - Never more than one enable low.
  - Undefined opcodes 1010–1101 issue empty execute words.
